// File: rtl/seq_detect_param_if.sv
// Bundles the configuration, serial-stream and result signals of seq_detect_param.
// The master modport drives the stream and config; the slave modport is the detector itself.
interface seq_detect_param_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               bit_i;
    logic               valid_i;
    logic               load_i;
    logic [MAX_LEN-1:0] pattern_i;
    logic [LEN_W-1:0]   len_i;
    logic               overlap_i;
    logic               clr_cnt_i;
    logic               seq_o;
    logic [CNT_W-1:0]   match_cnt_o;

    modport master (
        output bit_i, valid_i, load_i, pattern_i, len_i, overlap_i, clr_cnt_i,
        input  seq_o, match_cnt_o
    );

    modport slave (
        input  bit_i, valid_i, load_i, pattern_i, len_i, overlap_i, clr_cnt_i,
        output seq_o, match_cnt_o
    );
endinterface

// File: rtl/seq_detect_param.sv
// Programmable serial pattern detector: runtime-loaded pattern of 1..MAX_LEN bits,
// overlapping or non-overlapping matches, registered match pulse and saturating counter.
module seq_detect_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'('b1001),
    parameter int                 RST_LEN     = 4,
    parameter logic               RST_OVERLAP = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_detect_param_if.slave   bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    // Stream qualification: bit_i is consumed only on an edge with valid_i=1 and load_i=0;
    // there is no back-pressure, a load in the same cycle discards that bit.
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [LEN_W-1:0]   fill_q;
    logic               seq_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [MAX_LEN-1:0] hist_nxt;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill_inc;
    logic [LEN_W-1:0]   len_clamp;
    logic               shift_en;
    logic               hit;

    always_comb begin
        shift_en  = bus.valid_i && !bus.load_i;
        hist_nxt  = {hist_q[MAX_LEN-2:0], bus.bit_i};
        fill_inc  = (fill_q < len_q) ? fill_q + LEN_W'(1) : len_q;
        len_clamp = (bus.len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len_i;
        mask      = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < len_q) mask[i] = 1'b1;
        end
        // A zero-length pattern would trivially match, so it is treated as "disabled".
        hit = shift_en && (len_q != '0) && (fill_inc == len_q) &&
              ((hist_nxt & mask) == (pat_q & mask));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q  <= RST_PATTERN;
            len_q  <= LEN_W'(RST_LEN);
            ovl_q  <= RST_OVERLAP;
            hist_q <= '0;
            fill_q <= '0;
            seq_q  <= 1'b0;
        end else if (bus.load_i) begin
            pat_q  <= bus.pattern_i;
            len_q  <= len_clamp;
            ovl_q  <= bus.overlap_i;
            hist_q <= '0;
            fill_q <= '0;
            seq_q  <= 1'b0;
        end else begin
            seq_q <= hit;
            if (shift_en) begin
                hist_q <= hist_nxt;
                fill_q <= (hit && !ovl_q) ? '0 : fill_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (bus.clr_cnt_i) begin
            cnt_q <= '0;
        end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.seq_o       = seq_q;
    assign bus.match_cnt_o = cnt_q;
endmodule
